// File: rtl/pipe_hazard_ctrl.sv
// ID/EX pipeline sequencer: load-use bubble, EX-redirect flush, and a full-pipe freeze while data memory is busy.
// Outputs are zero-latency (Mealy); mem_busy overrides all else. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int WAIT_MAX     = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             rt_used_id,
    input  logic             re_idex,
    input  logic [4:0]       rt_idex,
    input  logic             redirect_ex,
    input  logic             mem_busy,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             freeze_pipe,
    output logic [1:0]       state_o,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam logic [3:0] FC_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WC_MAX  = 8'(WAIT_MAX);

    state_t     state;
    logic [3:0] fc;
    logic [7:0] wc;
    logic       luh;
    logic       h_pc, h_ifid, f_ifid, b_idex, frz;

    assign luh = re_idex && (rt_idex != 5'd0) &&
                 ((rt_idex == rs_id) || (rt_used_id && (rt_idex == rt_id)));

    // MEM_WAIT with mem_busy low falls through to the RUN rules, so a
    // redirect held during the freeze is honoured on the release cycle.
    always_comb begin
        h_pc   = 1'b0;
        h_ifid = 1'b0;
        f_ifid = 1'b0;
        b_idex = 1'b0;
        frz    = 1'b0;
        if (mem_busy) begin
            frz    = 1'b1;
            h_pc   = 1'b1;
            h_ifid = 1'b1;
        end else if (state == FLUSH) begin
            f_ifid = 1'b1;
            b_idex = 1'b1;
        end else if (redirect_ex) begin
            f_ifid = 1'b1;
            b_idex = 1'b1;
        end else if (luh) begin
            h_pc   = 1'b1;
            h_ifid = 1'b1;
            b_idex = 1'b1;
        end
    end

    assign hold_pc     = reset_n & h_pc;
    assign hold_ifid   = reset_n & h_ifid;
    assign flush_ifid  = reset_n & f_ifid;
    assign bubble_idex = reset_n & b_idex;
    assign freeze_pipe = reset_n & frz;
    assign state_o     = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            fc          <= 4'd0;
            wc          <= 8'd0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                FLUSH: begin
                    if (!mem_busy) begin
                        fc <= fc - 4'd1;
                        if (fc == 4'd1)
                            state <= RUN;
                    end
                end
                MEM_WAIT: begin
                    if (mem_busy) begin
                        if (wc < WC_MAX)
                            wc <= wc + 8'd1;
                        if (wc == WC_MAX)
                            err_timeout <= 1'b1;
                    end else if (redirect_ex && (FLUSH_CYCLES > 1)) begin
                        fc    <= FC_INIT;
                        state <= FLUSH;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    if (mem_busy) begin
                        wc    <= 8'd1;
                        state <= MEM_WAIT;
                    end else if (redirect_ex && (FLUSH_CYCLES > 1)) begin
                        fc    <= FC_INIT;
                        state <= FLUSH;
                    end
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] s_cnt, f_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_cnt <= '0;
            f_cnt <= '0;
        end else begin
            if (h_pc && !(&s_cnt))
                s_cnt <= s_cnt + CNT_W'(1);
            if (f_ifid && !(&f_cnt))
                f_cnt <= f_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = s_cnt;
    assign flush_cnt = f_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
